game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level Reversi game controller FSM.
- Drives the one-hot stage enables of the board datapath (draw board, initial pieces, highlight, validity check, place, flip, score, turn determination, remove highlight).
- Advances on each stage's `go` completion pulse.
- Synchronises and edge-detects the player keys, tracks the current player, detects game over, and guards every stage with a watchdog.

Parameters:
- TIMEOUT_W, 20: width of the per-stage watchdog counter; timeout fires at 2^TIMEOUT_W-1 cycles in one stage.
- SYNC_STAGES, 2: flip-flop stages on each key input before edge detection.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- key_enter, key_right, key_left, key_up, key_down  in  1 each  raw level inputs, active-high, asynchronous to clk
- go  in  1  datapath stage-complete pulse
- valid_move  in  1  datapath check result, sampled with go in CHECK
- has_turn  in  1  datapath turn result, sampled with go in HAS_TURN_OPP/HAS_TURN_CUR
- write_en  out  1  VGA write strobe
- draw_board_en, draw_initial_pieces_en, move_highlight_en, check_valid_move_en, place_en, flip_en, score_en, has_turn_en, turn_manager_en, remove_highlight_en  out  1 each  stage enables, at most one high
- move_right_en, move_left_en, move_up_en, move_down_en  out  1 each  single-cycle cursor step
- determine_opponent, determine_current  out  1 each  qualifiers for has_turn_en
- current_player  out  1  0 = black, 1 = white
- invalid_move  out  1  1-cycle pulse on a rejected placement
- game_over  out  1  sticky until reset
- timeout_err  out  1  sticky until reset

Behaviour:
- Reset:
  - resetn low forces state RESET immediately; the reset is asynchronous and applies mid-operation too.
  - All outputs are 0 during reset, including current_player (black) and the sync/edge registers.
- Enables:
  - Every enable is registered and is a Moore decode of the state.
  - The enable rises on the cycle after the state is entered.
  - The enable is held until go is sampled high in that state.
  - go is only honoured in a stage state; go elsewhere is ignored.
- Transition on go:
  - The next state is taken on the cycle after go.
  - The enable drops the same cycle the new state is entered.
  - A new stage's enable is asserted one cycle later, so there is a guaranteed 1-cycle all-low gap between stages.
- write_en = draw_board_en | draw_initial_pieces_en | move_highlight_en | place_en | flip_en | remove_highlight_en.
- Key handling:
  - Each key passes through a SYNC_STAGES synchroniser, then a rising-edge detector.
  - Edges are consumed only in IDLE; edges arriving in other states are dropped.
  - Simultaneous edges are resolved by priority: enter > right > left > up > down.
- States:
  - RESET -> DRAW_BOARD, unconditionally after 1 cycle.
  - DRAW_BOARD -(go)-> DRAW_INIT.
  - DRAW_INIT -(go)-> HIGHLIGHT.
  - HIGHLIGHT (move_highlight_en) -(go)-> IDLE.
  - IDLE:
    - direction edge -> MOVE;
    - enter edge -> CHECK;
    - otherwise stay.
  - MOVE: the matching move_*_en is asserted for exactly 1 cycle, then -> HIGHLIGHT. MOVE needs no go.
  - CHECK -(go):
    - valid_move=1 -> PLACE;
    - valid_move=0 -> IDLE with invalid_move pulsed 1 cycle.
  - PLACE -(go)-> FLIP -(go)-> SCORE -(go)-> HAS_TURN_OPP.
  - HAS_TURN_OPP (has_turn_en, determine_opponent) -(go):
    - has_turn=1 -> SWITCH;
    - has_turn=0 -> HAS_TURN_CUR.
  - SWITCH (turn_manager_en) -(go)-> HIGHLIGHT; current_player toggles on the go cycle.
  - HAS_TURN_CUR (has_turn_en, determine_current) -(go):
    - has_turn=1 -> HIGHLIGHT; the same player moves again and current_player is unchanged;
    - has_turn=0 -> END.
  - END (remove_highlight_en) -(go)-> OVER.
  - OVER: game_over=1; all enables 0; key edges are ignored; the only exit is reset.
- Watchdog:
  - The counter clears on every state change.
  - It increments each cycle spent in a go-waiting state and saturates.
  - At all-ones: timeout_err=1 (sticky) and the FSM -> OVER. game_over is not set by a timeout.
  - IDLE, MOVE, RESET and OVER are exempt.
- go on the same cycle as the watchdog reaching terminal count: go wins.

Decomposition:
- Shared package `reversi_pkg`: state enum (4-bit encoding), the PLAYER_BLACK/PLAYER_WHITE constants, and the key index constants.
- One sub-module, `key_edge_sync`: parameterised by SYNC_STAGES; 5-bit input vector, 5-bit 1-cycle edge-pulse output; async active-low reset. Instantiated once.

Test Plan:
1. Reset release, go pulsed 3 cycles after each enable rises:
   - draw_board_en high at cycle 2;
   - then draw_initial_pieces_en, then move_highlight_en;
   - IDLE reached with all enables 0 and current_player=0.
2. In IDLE, key_right and key_up rise on the same cycle:
   - exactly one move_right_en pulse of width 1 after the sync latency;
   - no move_up_en;
   - then move_highlight_en.
3. Enter, check go with valid_move=0:
   - invalid_move is a 1-cycle pulse;
   - the FSM returns to IDLE;
   - place_en never asserts.
4. Enter, valid_move=1:
   - place, flip, score, has_turn_en with determine_opponent=1;
   - has_turn=1 -> turn_manager_en;
   - current_player becomes 1, then highlight.
5. Opponent has_turn=0, then current has_turn=0:
   - determine_current=1 phase observed;
   - remove_highlight_en;
   - game_over=1;
   - subsequent key edges produce no enables.
6. Run with TIMEOUT_W=4 and withhold go in FLIP:
   - timeout_err=1 after 15 cycles in FLIP;
   - state OVER with game_over=0;
   - resetn low mid-stage clears everything within the same cycle.

Source files
------------

// File: rtl/reversi_pkg.sv
// +-------------------------------------------------------------------------+
// | reversi_pkg : shared state encoding, player and key/enable indices      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

package reversi_pkg;

  typedef enum logic [3:0] {
    S_RESET        = 4'd0,
    S_DRAW_BOARD   = 4'd1,
    S_DRAW_INIT    = 4'd2,
    S_HIGHLIGHT    = 4'd3,
    S_IDLE         = 4'd4,
    S_MOVE         = 4'd5,
    S_CHECK        = 4'd6,
    S_PLACE        = 4'd7,
    S_FLIP         = 4'd8,
    S_SCORE        = 4'd9,
    S_HAS_TURN_OPP = 4'd10,
    S_SWITCH       = 4'd11,
    S_HAS_TURN_CUR = 4'd12,
    S_END          = 4'd13,
    S_OVER         = 4'd14
  } state_e;

  localparam logic PLAYER_BLACK = 1'b0;
  localparam logic PLAYER_WHITE = 1'b1;

  localparam int NUM_KEYS  = 5;
  localparam int KEY_ENTER = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_UP    = 3;
  localparam int KEY_DOWN  = 4;

  // Bits 0..9 are the mutually exclusive stage enables; 10..11 qualify has_turn.
  localparam int NUM_EN        = 12;
  localparam int EN_DRAW_BOARD = 0;
  localparam int EN_DRAW_INIT  = 1;
  localparam int EN_HIGHLIGHT  = 2;
  localparam int EN_CHECK      = 3;
  localparam int EN_PLACE      = 4;
  localparam int EN_FLIP       = 5;
  localparam int EN_SCORE      = 6;
  localparam int EN_HAS_TURN   = 7;
  localparam int EN_TURN_MGR   = 8;
  localparam int EN_REMOVE_HL  = 9;
  localparam int EN_DET_OPP    = 10;
  localparam int EN_DET_CUR    = 11;

  function automatic logic [NUM_EN-1:0] stage_enables(input state_e s);
    logic [NUM_EN-1:0] en;
    en = '0;
    case (s)
      S_DRAW_BOARD:   en[EN_DRAW_BOARD] = 1'b1;
      S_DRAW_INIT:    en[EN_DRAW_INIT]  = 1'b1;
      S_HIGHLIGHT:    en[EN_HIGHLIGHT]  = 1'b1;
      S_CHECK:        en[EN_CHECK]      = 1'b1;
      S_PLACE:        en[EN_PLACE]      = 1'b1;
      S_FLIP:         en[EN_FLIP]       = 1'b1;
      S_SCORE:        en[EN_SCORE]      = 1'b1;
      S_HAS_TURN_OPP: begin
        en[EN_HAS_TURN] = 1'b1;
        en[EN_DET_OPP]  = 1'b1;
      end
      S_SWITCH:       en[EN_TURN_MGR]   = 1'b1;
      S_HAS_TURN_CUR: begin
        en[EN_HAS_TURN] = 1'b1;
        en[EN_DET_CUR]  = 1'b1;
      end
      S_END:          en[EN_REMOVE_HL]  = 1'b1;
      default:        en = '0;
    endcase
    return en;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_edge_sync.sv
// +-------------------------------------------------------------------------+
// | key_edge_sync : multi-stage synchroniser plus rising-edge pulse per key |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module key_edge_sync
  import reversi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic [NUM_KEYS-1:0] edges_o
);

  logic [NUM_KEYS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_KEYS-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= keys_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edges_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
// +-------------------------------------------------------------------------+
// | game_sequencer : Reversi top-level controller FSM with stage watchdog   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module game_sequencer
  import reversi_pkg::*;
#(
  parameter int TIMEOUT_W   = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_enter,
  input  logic key_right,
  input  logic key_left,
  input  logic key_up,
  input  logic key_down,
  input  logic go,
  input  logic valid_move,
  input  logic has_turn,
  output logic write_en,
  output logic draw_board_en,
  output logic draw_initial_pieces_en,
  output logic move_highlight_en,
  output logic check_valid_move_en,
  output logic place_en,
  output logic flip_en,
  output logic score_en,
  output logic has_turn_en,
  output logic turn_manager_en,
  output logic remove_highlight_en,
  output logic move_right_en,
  output logic move_left_en,
  output logic move_up_en,
  output logic move_down_en,
  output logic determine_opponent,
  output logic determine_current,
  output logic current_player,
  output logic invalid_move,
  output logic game_over,
  output logic timeout_err
);

  localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;

  state_e               state_q, state_d;
  logic [NUM_EN-1:0]    en_q, en_d, cur_en;
  logic [3:0]           dir_q, dir_d, move_q, move_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 player_q, player_d;
  logic                 invalid_q, invalid_d;
  logic                 over_q, over_d;
  logic                 tout_q, tout_d;
  logic [NUM_KEYS-1:0]  keys_raw, key_edge;
  logic                 in_stage;

  assign keys_raw[KEY_ENTER] = key_enter;
  assign keys_raw[KEY_RIGHT] = key_right;
  assign keys_raw[KEY_LEFT]  = key_left;
  assign keys_raw[KEY_UP]    = key_up;
  assign keys_raw[KEY_DOWN]  = key_down;

  key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_key_edge_sync (
    .clk_i  (clk),
    .rst_ni (resetn),
    .keys_i (keys_raw),
    .edges_o(key_edge)
  );

  assign cur_en   = stage_enables(state_q);
  assign in_stage = |cur_en[EN_REMOVE_HL:EN_DRAW_BOARD];

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    move_d    = '0;
    player_d  = player_q;
    invalid_d = 1'b0;
    over_d    = over_q;
    tout_d    = tout_q;

    case (state_q)
      S_RESET:      state_d = S_DRAW_BOARD;
      S_DRAW_BOARD: if (go) state_d = S_DRAW_INIT;
      S_DRAW_INIT:  if (go) state_d = S_HIGHLIGHT;
      S_HIGHLIGHT:  if (go) state_d = S_IDLE;
      S_IDLE: begin
        if (key_edge[KEY_ENTER]) begin
          state_d = S_CHECK;
        end else if (|key_edge[KEY_DOWN:KEY_RIGHT]) begin
          state_d = S_MOVE;
          if (key_edge[KEY_RIGHT])     dir_d = 4'b0001;
          else if (key_edge[KEY_LEFT]) dir_d = 4'b0010;
          else if (key_edge[KEY_UP])   dir_d = 4'b0100;
          else                         dir_d = 4'b1000;
        end
      end
      // First cycle issues the step, second cycle (step visible) leaves.
      S_MOVE: begin
        if (|move_q) state_d = S_HIGHLIGHT;
        else         move_d  = dir_q;
      end
      S_CHECK: begin
        if (go) begin
          if (valid_move) begin
            state_d = S_PLACE;
          end else begin
            state_d   = S_IDLE;
            invalid_d = 1'b1;
          end
        end
      end
      S_PLACE:        if (go) state_d = S_FLIP;
      S_FLIP:         if (go) state_d = S_SCORE;
      S_SCORE:        if (go) state_d = S_HAS_TURN_OPP;
      S_HAS_TURN_OPP: if (go) state_d = has_turn ? S_SWITCH : S_HAS_TURN_CUR;
      S_SWITCH: begin
        if (go) begin
          state_d  = S_HIGHLIGHT;
          player_d = (player_q == PLAYER_BLACK) ? PLAYER_WHITE : PLAYER_BLACK;
        end
      end
      S_HAS_TURN_CUR: if (go) state_d = has_turn ? S_HIGHLIGHT : S_END;
      S_END: begin
        if (go) begin
          state_d = S_OVER;
          over_d  = 1'b1;
        end
      end
      S_OVER:  state_d = S_OVER;
      default: state_d = S_RESET;
    endcase

    // A go arriving on the terminal-count cycle still wins.
    if (in_stage && !go && (wdog_q == WDOG_MAX)) begin
      state_d = S_OVER;
      tout_d  = 1'b1;
    end

    if (state_d != state_q)                    wdog_d = '0;
    else if (in_stage && (wdog_q != WDOG_MAX)) wdog_d = wdog_q + TIMEOUT_W'(1);
    else                                       wdog_d = wdog_q;

    en_d = (state_d == state_q) ? cur_en : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_RESET;
      en_q      <= '0;
      dir_q     <= '0;
      move_q    <= '0;
      wdog_q    <= '0;
      player_q  <= PLAYER_BLACK;
      invalid_q <= 1'b0;
      over_q    <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      dir_q     <= dir_d;
      move_q    <= move_d;
      wdog_q    <= wdog_d;
      player_q  <= player_d;
      invalid_q <= invalid_d;
      over_q    <= over_d;
      tout_q    <= tout_d;
    end
  end

  assign draw_board_en          = en_q[EN_DRAW_BOARD];
  assign draw_initial_pieces_en = en_q[EN_DRAW_INIT];
  assign move_highlight_en      = en_q[EN_HIGHLIGHT];
  assign check_valid_move_en    = en_q[EN_CHECK];
  assign place_en               = en_q[EN_PLACE];
  assign flip_en                = en_q[EN_FLIP];
  assign score_en               = en_q[EN_SCORE];
  assign has_turn_en            = en_q[EN_HAS_TURN];
  assign turn_manager_en        = en_q[EN_TURN_MGR];
  assign remove_highlight_en    = en_q[EN_REMOVE_HL];
  assign determine_opponent     = en_q[EN_DET_OPP];
  assign determine_current      = en_q[EN_DET_CUR];

  assign write_en = en_q[EN_DRAW_BOARD] | en_q[EN_DRAW_INIT] | en_q[EN_HIGHLIGHT] |
                    en_q[EN_PLACE] | en_q[EN_FLIP] | en_q[EN_REMOVE_HL];

  assign move_right_en  = move_q[0];
  assign move_left_en   = move_q[1];
  assign move_up_en     = move_q[2];
  assign move_down_en   = move_q[3];

  assign current_player = player_q;
  assign invalid_move   = invalid_q;
  assign game_over      = over_q;
  assign timeout_err    = tout_q;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// +-------------------------------------------------------------------------+
// | tb_game_sequencer : randomized scoreboard bench for game_sequencer      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_game_sequencer;

  localparam int TW = 4;

  // Observation vector bit positions.
  localparam int B_DB = 0, B_DI = 1, B_HL = 2, B_CV = 3, B_PLACE = 4, B_FLIP = 5;
  localparam int B_SCORE = 6, B_HT = 7, B_TM = 8, B_RH = 9, B_MR = 10;
  localparam int B_DO = 14, B_DC = 15, B_CP = 16, B_INV = 17, B_GO = 18, B_TO = 19, B_WE = 20;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic key_enter = 1'b0, key_right = 1'b0, key_left = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic go = 1'b0, valid_move = 1'b0, has_turn = 1'b0;
  logic write_en, draw_board_en, draw_initial_pieces_en, move_highlight_en;
  logic check_valid_move_en, place_en, flip_en, score_en, has_turn_en;
  logic turn_manager_en, remove_highlight_en;
  logic move_right_en, move_left_en, move_up_en, move_down_en;
  logic determine_opponent, determine_current, current_player;
  logic invalid_move, game_over, timeout_err;

  always #5 clk = ~clk;

  game_sequencer #(.TIMEOUT_W(TW), .SYNC_STAGES(2)) dut (
    .clk                   (clk),
    .resetn                (resetn),
    .key_enter             (key_enter),
    .key_right             (key_right),
    .key_left              (key_left),
    .key_up                (key_up),
    .key_down              (key_down),
    .go                    (go),
    .valid_move            (valid_move),
    .has_turn              (has_turn),
    .write_en              (write_en),
    .draw_board_en         (draw_board_en),
    .draw_initial_pieces_en(draw_initial_pieces_en),
    .move_highlight_en     (move_highlight_en),
    .check_valid_move_en   (check_valid_move_en),
    .place_en              (place_en),
    .flip_en               (flip_en),
    .score_en              (score_en),
    .has_turn_en           (has_turn_en),
    .turn_manager_en       (turn_manager_en),
    .remove_highlight_en   (remove_highlight_en),
    .move_right_en         (move_right_en),
    .move_left_en          (move_left_en),
    .move_up_en            (move_up_en),
    .move_down_en          (move_down_en),
    .determine_opponent    (determine_opponent),
    .determine_current     (determine_current),
    .current_player        (current_player),
    .invalid_move          (invalid_move),
    .game_over             (game_over),
    .timeout_err           (timeout_err)
  );

  logic [20:0] obs;
  assign obs = {write_en, timeout_err, game_over, invalid_move, current_player,
                determine_current, determine_opponent,
                move_down_en, move_up_en, move_left_en, move_right_en,
                remove_highlight_en, turn_manager_en, has_turn_en, score_en, flip_en,
                place_en, check_valid_move_en, move_highlight_en,
                draw_initial_pieces_en, draw_board_en};

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [20:0] exp_q[$];
  logic [20:0] prev_obs = '0;
  bit          mon_en   = 1'b0;
  bit          m_player, m_over, m_tout;

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one expected vector per visible output change.
  function automatic logic [20:0] mk(input int idx, input bit dop, input bit dcur, input bit inv);
    logic [20:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    if (idx inside {B_DB, B_DI, B_HL, B_PLACE, B_FLIP, B_RH}) v[B_WE] = 1'b1;
    v[B_DO]  = dop;
    v[B_DC]  = dcur;
    v[B_INV] = inv;
    v[B_CP]  = m_player;
    v[B_GO]  = m_over;
    v[B_TO]  = m_tout;
    return v;
  endfunction

  task automatic push_stage(input int idx);
    exp_q.push_back(mk(idx, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(-1, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic m_boot();
    push_stage(B_DB);
    push_stage(B_DI);
    push_stage(B_HL);
  endtask

  task automatic m_direction(input logic [4:0] k);
    // Directions by priority right > left > up > down (key indices 1..4).
    for (int i = 1; i <= 4; i++) begin
      if (k[i]) begin
        push_stage(B_MR + i - 1);
        break;
      end
    end
    push_stage(B_HL);
  endtask

  task automatic m_enter(input bit vm, input bit opp, input bit cur);
    if (!vm) begin
      exp_q.push_back(mk(B_CV, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(-1, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(mk(-1, 1'b0, 1'b0, 1'b0));
      return;
    end
    push_stage(B_CV);
    push_stage(B_PLACE);
    push_stage(B_FLIP);
    push_stage(B_SCORE);
    exp_q.push_back(mk(B_HT, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(-1, 1'b0, 1'b0, 1'b0));
    if (opp) begin
      exp_q.push_back(mk(B_TM, 1'b0, 1'b0, 1'b0));
      m_player = ~m_player;
      exp_q.push_back(mk(-1, 1'b0, 1'b0, 1'b0));
      push_stage(B_HL);
    end else begin
      exp_q.push_back(mk(B_HT, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(mk(-1, 1'b0, 1'b0, 1'b0));
      if (cur) begin
        push_stage(B_HL);
      end else begin
        exp_q.push_back(mk(B_RH, 1'b0, 1'b0, 1'b0));
        m_over = 1'b1;
        exp_q.push_back(mk(-1, 1'b0, 1'b0, 1'b0));
      end
    end
  endtask

  // Monitor: every change of the output vector must match the next expectation.
  always @(negedge clk) begin
    if (mon_en && (obs !== prev_obs)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h, required no change from %h at %0t",
                 obs, prev_obs, $time);
      end else begin
        check("output_sequence", obs, exp_q.pop_front());
      end
    end
    prev_obs = obs;
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic set_keys(input logic [4:0] k);
    key_enter = k[0];
    key_right = k[1];
    key_left  = k[2];
    key_up    = k[3];
    key_down  = k[4];
  endtask

  task automatic press(input logic [4:0] k);
    set_keys(k);
    tick(3);
    set_keys(5'b0);
    tick(3);
  endtask

  task automatic serve(input int idx, input bit vm, input bit ht, input int dly);
    int waited;
    waited = 0;
    while (!obs[idx] && waited < 40) begin
      tick(1);
      waited++;
    end
    check($sformatf("enable_%0d_seen", idx), {20'b0, obs[idx]}, 21'd1);
    tick((dly < 0) ? int'($urandom_range(0, 3)) : dly);
    go         = 1'b1;
    valid_move = vm;
    has_turn   = ht;
    tick(1);
    go         = 1'b0;
    valid_move = 1'b0;
    has_turn   = 1'b0;
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    resetn = 1'b0;
    set_keys(5'b0);
    go = 1'b0;
    #1;
    check("reset_clears_outputs", obs, 21'd0);
    tick(2);
    exp_q.delete();
    m_player = 1'b0;
    m_over   = 1'b0;
    m_tout   = 1'b0;
    m_boot();
    resetn = 1'b1;
    mon_en = 1'b1;
    tick(1);
    check("draw_board_en_cycle1", {20'b0, draw_board_en}, 21'd0);
    tick(1);
    check("draw_board_en_cycle2", {20'b0, draw_board_en}, 21'd1);
  endtask

  task automatic boot();
    serve(B_DB, 1'b0, 1'b0, 3);
    serve(B_DI, 1'b0, 1'b0, 3);
    serve(B_HL, 1'b0, 1'b0, 3);
    check("idle_after_boot", obs, 21'd0);
  endtask

  task automatic do_move(input logic [4:0] k);
    m_direction(k);
    press(k);
    serve(B_HL, 1'b0, 1'b0, -1);
  endtask

  task automatic do_enter(input logic [4:0] k, input bit vm, input bit opp, input bit cur);
    m_enter(vm, opp, cur);
    press(k);
    serve(B_CV, vm, 1'b0, -1);
    if (vm) begin
      serve(B_PLACE, 1'b0, 1'b0, -1);
      serve(B_FLIP, 1'b0, 1'b0, -1);
      serve(B_SCORE, 1'b0, 1'b0, -1);
      serve(B_HT, 1'b0, opp, -1);
      if (opp) begin
        serve(B_TM, 1'b0, 1'b0, -1);
        serve(B_HL, 1'b0, 1'b0, -1);
      end else begin
        serve(B_HT, 1'b0, cur, -1);
        if (cur) serve(B_HL, 1'b0, 1'b0, -1);
        else     serve(B_RH, 1'b0, 1'b0, -1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: run did not complete, required completion");
    $fatal(1);
  end

  initial begin
    logic [4:0]  k;
    logic [20:0] v;
    int          cnt;

    tick(1);
    apply_reset();
    boot();

    do_move(5'b01010);              // right and up together: right wins
    do_enter(5'b00001, 1'b0, 1'b0, 1'b0);
    do_enter(5'b00001, 1'b1, 1'b1, 1'b0);
    check("player_white_after_switch", {20'b0, current_player}, 21'd1);

    for (int i = 0; i < 16; i++) begin
      k = 5'($urandom_range(1, 31));
      if (k[0]) do_enter(k, 1'($urandom), 1'($urandom), 1'b1);
      else      do_move(k);
    end

    do_enter(5'b00001, 1'b1, 1'b0, 1'b0);
    tick(2);
    v = '0;
    v[B_GO] = 1'b1;
    v[B_CP] = m_player;
    check("game_over_state", obs, v);
    press(5'b11111);
    press(5'b00010);
    tick(4);
    check("over_ignores_keys", obs, v);

    // Watchdog: withhold go in FLIP.
    apply_reset();
    boot();
    push_stage(B_CV);
    push_stage(B_PLACE);
    exp_q.push_back(mk(B_FLIP, 1'b0, 1'b0, 1'b0));
    m_tout = 1'b1;
    exp_q.push_back(mk(-1, 1'b0, 1'b0, 1'b0));
    press(5'b00001);
    serve(B_CV, 1'b1, 1'b0, -1);
    serve(B_PLACE, 1'b0, 1'b0, -1);
    cnt = 0;
    while (!flip_en && cnt < 40) begin
      tick(1);
      cnt++;
    end
    cnt = 0;
    while (flip_en && cnt < 40) begin
      tick(1);
      cnt++;
    end
    check("flip_cycles_before_timeout", 21'(cnt), 21'd15);
    check("timeout_err_set", {20'b0, timeout_err}, 21'd1);
    check("timeout_no_game_over", {20'b0, game_over}, 21'd0);
    press(5'b00100);
    tick(3);
    v = '0;
    v[B_TO] = 1'b1;
    check("timeout_over_ignores_keys", obs, v);

    // Asynchronous reset in the middle of a stage.
    apply_reset();
    serve(B_DB, 1'b0, 1'b0, -1);
    cnt = 0;
    while (!draw_initial_pieces_en && cnt < 40) begin
      tick(1);
      cnt++;
    end
    #2;
    apply_reset();
    boot();

    tick(2);
    check("scoreboard_drained", 21'(exp_q.size()), 21'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
